// File: rtl/ex_pkg.sv
// Shared types for the RV32I execute stage: ALU opcodes, operand selects,
// the EX/MEM register layout and the forwarding-mux helper.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic OPA_RS1 = 1'b0;
  localparam logic OPA_PC  = 1'b1;
  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] alu_data;
    logic [31:0] store_data;
    logic [31:0] pc;
  } ex_mem_t;

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [31:0] fwd_mux(
    input logic [4:0]  src_addr,
    input logic [31:0] rf_data,
    input logic [4:0]  mem_addr,
    input logic        mem_wren,
    input logic [31:0] mem_data,
    input logic [4:0]  wb_addr,
    input logic        wb_wren,
    input logic [31:0] wb_data
  );
    if (mem_wren && (mem_addr != 5'd0) && (mem_addr == src_addr)) return mem_data;
    if (wb_wren && (wb_addr != 5'd0) && (wb_addr == src_addr)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/sll_32.sv
// 32-bit logical left barrel shifter, five binary-weighted levels.
module sll_32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);

  logic [31:0] stage [0:5];

  assign stage[0] = a;

  for (genvar gi = 0; gi < 5; gi++) begin : g_level
    localparam int S = 1 << gi;
    assign stage[gi+1] = shamt[gi] ? {stage[gi][31-S:0], {S{1'b0}}} : stage[gi];
  end

  assign y = stage[5];

endmodule

// File: rtl/srl_32.sv
// 32-bit right barrel shifter; arith=1 fills with a[31] (SRA), else zeros (SRL).
module srl_32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] y
);

  logic [31:0] stage [0:5];
  logic        fill;

  assign fill     = arith & a[31];
  assign stage[0] = a;

  for (genvar gi = 0; gi < 5; gi++) begin : g_level
    localparam int S = 1 << gi;
    assign stage[gi+1] = shamt[gi] ? {{S{fill}}, stage[gi][31:S]} : stage[gi];
  end

  assign y = stage[5];

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU and EX/MEM register.
// Define EX_FWD_EN to enable MEM/WB forwarding; otherwise the hazard unit must stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rd_addr,
  input  logic [3:0]      i_alu_op,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic            i_rd_wren,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic            i_mem_rd_wren,
  input  logic [XLEN-1:0] i_mem_alu_data,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic            i_wb_rd_wren,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_alu_data,
  output logic [XLEN-1:0] o_store_data,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_wren,
  output logic [XLEN-1:0] o_pc
);

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] sll_y;
  logic [31:0] srl_y;
  logic [31:0] alu_y;
  ex_mem_t     ex_mem_reg;
  ex_mem_t     ex_mem_next;

`ifdef EX_FWD_EN
  assign rs1_fwd = fwd_mux(i_rs1_addr, i_rs1_data, i_mem_rd_addr, i_mem_rd_wren,
                           i_mem_alu_data, i_wb_rd_addr, i_wb_rd_wren, i_wb_data);
  assign rs2_fwd = fwd_mux(i_rs2_addr, i_rs2_data, i_mem_rd_addr, i_mem_rd_wren,
                           i_mem_alu_data, i_wb_rd_addr, i_wb_rd_wren, i_wb_data);
`else
  // Forwarding ports stay in the port list so both builds share one netlist shell.
  logic unused_fwd;
  assign unused_fwd = ^{i_rs1_addr, i_rs2_addr, i_mem_rd_addr, i_mem_rd_wren,
                        i_mem_alu_data, i_wb_rd_addr, i_wb_rd_wren, i_wb_data};
  assign rs1_fwd = i_rs1_data;
  assign rs2_fwd = i_rs2_data;
`endif

  assign op_a  = (i_opa_sel == OPA_PC)  ? i_pc  : rs1_fwd;
  assign op_b  = (i_opb_sel == OPB_IMM) ? i_imm : rs2_fwd;
  assign shamt = op_b[4:0];

  sll_32 u_sll (
    .a     (op_a),
    .shamt (shamt),
    .y     (sll_y)
  );

  srl_32 u_srl (
    .a     (op_a),
    .shamt (shamt),
    .arith (i_alu_op == ALU_SRA),
    .y     (srl_y)
  );

  always_comb begin
    alu_y = '0;
    case (alu_op_e'(i_alu_op))
      ALU_ADD:   alu_y = op_a + op_b;
      ALU_SUB:   alu_y = op_a - op_b;
      ALU_SLL:   alu_y = sll_y;
      ALU_SLT:   alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_y = {31'd0, op_a < op_b};
      ALU_XOR:   alu_y = op_a ^ op_b;
      ALU_SRL:   alu_y = srl_y;
      ALU_SRA:   alu_y = srl_y;
      ALU_OR:    alu_y = op_a | op_b;
      ALU_AND:   alu_y = op_a & op_b;
      ALU_PASSB: alu_y = op_b;
      default:   alu_y = '0;
    endcase
  end

  // A flushed entry still captures its data fields; only valid/wren are squashed.
  always_comb begin
    ex_mem_next            = '0;
    ex_mem_next.valid      = i_id_valid & ~i_flush;
    ex_mem_next.rd_wren    = i_rd_wren & i_id_valid & ~i_flush;
    ex_mem_next.rd_addr    = i_rd_addr;
    ex_mem_next.alu_data   = alu_y;
    ex_mem_next.store_data = rs2_fwd;
    ex_mem_next.pc         = i_pc;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_mem_reg <= '0;
    end else if (i_flush || !i_stall) begin
      ex_mem_reg <= ex_mem_next;
    end
  end

  assign o_ex_valid   = ex_mem_reg.valid;
  assign o_rd_wren    = ex_mem_reg.rd_wren;
  assign o_rd_addr    = ex_mem_reg.rd_addr;
  assign o_alu_data   = ex_mem_reg.alu_data;
  assign o_store_data = ex_mem_reg.store_data;
  assign o_pc         = ex_mem_reg.pc;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; expectations follow the EX_FWD_EN setting.
module tb_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_flush;
  logic        i_id_valid;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_imm;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [4:0]  i_rd_addr;
  logic [3:0]  i_alu_op;
  logic        i_opa_sel;
  logic        i_opb_sel;
  logic        i_rd_wren;
  logic [4:0]  i_mem_rd_addr;
  logic        i_mem_rd_wren;
  logic [31:0] i_mem_alu_data;
  logic [4:0]  i_wb_rd_addr;
  logic        i_wb_rd_wren;
  logic [31:0] i_wb_data;
  logic        o_ex_valid;
  logic [31:0] o_alu_data;
  logic [31:0] o_store_data;
  logic [4:0]  o_rd_addr;
  logic        o_rd_wren;
  logic [31:0] o_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  ex_stage #(.XLEN(32)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_stall        (i_stall),
    .i_flush        (i_flush),
    .i_id_valid     (i_id_valid),
    .i_pc           (i_pc),
    .i_rs1_data     (i_rs1_data),
    .i_rs2_data     (i_rs2_data),
    .i_imm          (i_imm),
    .i_rs1_addr     (i_rs1_addr),
    .i_rs2_addr     (i_rs2_addr),
    .i_rd_addr      (i_rd_addr),
    .i_alu_op       (i_alu_op),
    .i_opa_sel      (i_opa_sel),
    .i_opb_sel      (i_opb_sel),
    .i_rd_wren      (i_rd_wren),
    .i_mem_rd_addr  (i_mem_rd_addr),
    .i_mem_rd_wren  (i_mem_rd_wren),
    .i_mem_alu_data (i_mem_alu_data),
    .i_wb_rd_addr   (i_wb_rd_addr),
    .i_wb_rd_wren   (i_wb_rd_wren),
    .i_wb_data      (i_wb_data),
    .o_ex_valid     (o_ex_valid),
    .o_alu_data     (o_alu_data),
    .o_store_data   (o_store_data),
    .o_rd_addr      (o_rd_addr),
    .o_rd_wren      (o_rd_wren),
    .o_pc           (o_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_stall = 0; i_flush = 0; i_id_valid = 1; i_pc = 32'h0;
    i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;
    i_rs1_addr = 5'd1; i_rs2_addr = 5'd2; i_rd_addr = 5'd5;
    i_alu_op = 4'd0; i_opa_sel = 0; i_opb_sel = 0; i_rd_wren = 1;
    i_mem_rd_addr = 0; i_mem_rd_wren = 0; i_mem_alu_data = 0;
    i_wb_rd_addr = 0; i_wb_rd_wren = 0; i_wb_data = 0;
  endtask

  // One ALU transaction: A from rs1, B from rs2 or imm.
  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic bsel, input logic [31:0] exp);
    i_alu_op = op; i_rs1_data = a; i_opa_sel = 0; i_opb_sel = bsel;
    if (bsel) i_imm = b; else i_rs2_data = b;
    step();
    $display("vec %-6s op=%0d a=%08h b=%08h -> %08h", tag, op, a, b, o_alu_data);
    check(tag, o_alu_data, exp);
    check({tag, "_v"}, {31'd0, o_ex_valid}, 32'd1);
  endtask

  logic [31:0] exp_fwd;

  initial begin
    idle_inputs();
    i_rst_n = 0;
    step();
    $display("vec reset");
    check("rst_valid", {31'd0, o_ex_valid}, 0);
    check("rst_wren",  {31'd0, o_rd_wren}, 0);
    check("rst_alu",   o_alu_data, 0);
    check("rst_store", o_store_data, 0);
    check("rst_rd",    {27'd0, o_rd_addr}, 0);
    check("rst_pc",    o_pc, 0);
    i_rst_n = 1;

    i_pc = 32'h100; i_rd_addr = 5'd7;
    alu_vec("add", 4'd0, 32'd5, 32'hFFFF_FFFD, 1'b1, 32'd2);
    check("add_wren", {31'd0, o_rd_wren}, 1);
    check("add_rd", {27'd0, o_rd_addr}, 7);
    check("add_pc", o_pc, 32'h100);
    alu_vec("sub",   4'd1,  32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE);
    alu_vec("sra",   4'd7,  32'h8000_0000,  32'h24,         1'b0, 32'hF800_0000);
    alu_vec("srl",   4'd6,  32'h8000_0000,  32'h24,         1'b0, 32'h0800_0000);
    alu_vec("sll",   4'd2,  32'd1,          32'd31,         1'b0, 32'h8000_0000);
    alu_vec("sltu",  4'd4,  32'd1,          32'hFFFF_FFFF,  1'b0, 32'd1);
    alu_vec("slt",   4'd3,  32'd1,          32'hFFFF_FFFF,  1'b0, 32'd0);
    alu_vec("or",    4'd8,  32'hF000_000F,  32'h0F00_00F0,  1'b0, 32'hFF00_00FF);
    alu_vec("and",   4'd9,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 32'h0F00_0F00);
    alu_vec("lui",   4'd10, 32'h1234_5678,  32'hABCD_E000,  1'b1, 32'hABCD_E000);
    alu_vec("op12",  4'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd0);
    i_opb_sel = 0;

    // AUIPC-style: operand A is the PC
    i_alu_op = 4'd0; i_opa_sel = 1; i_opb_sel = 1; i_pc = 32'h1000; i_imm = 32'h2000;
    step();
    $display("vec auipc -> %08h", o_alu_data);
    check("auipc", o_alu_data, 32'h3000);
    i_opa_sel = 0;

    // Forwarding: rs1 = rs2 = x3, MEM and WB both target x3.
    i_alu_op = 4'd0; i_opb_sel = 1; i_imm = 0;
    i_rs1_addr = 5'd3; i_rs2_addr = 5'd3; i_rs1_data = 32'h100; i_rs2_data = 32'h200;
    i_mem_rd_addr = 5'd3; i_mem_rd_wren = 1; i_mem_alu_data = 32'h11;
    i_wb_rd_addr = 5'd3; i_wb_rd_wren = 1; i_wb_data = 32'h22;
    step();
    $display("vec fwd_mem -> %08h store %08h", o_alu_data, o_store_data);
`ifdef EX_FWD_EN
    exp_fwd = 32'h11;
`else
    exp_fwd = 32'h100;
`endif
    check("fwd_mem", o_alu_data, exp_fwd);
`ifdef EX_FWD_EN
    exp_fwd = 32'h11;
`else
    exp_fwd = 32'h200;
`endif
    check("fwd_store", o_store_data, exp_fwd);

    i_mem_rd_addr = 5'd4;
    step();
    $display("vec fwd_wb -> %08h", o_alu_data);
`ifdef EX_FWD_EN
    exp_fwd = 32'h22;
`else
    exp_fwd = 32'h100;
`endif
    check("fwd_wb", o_alu_data, exp_fwd);

    i_rs1_addr = 5'd0; i_mem_rd_addr = 5'd0; i_wb_rd_addr = 5'd0;
    step();
    $display("vec fwd_x0 -> %08h", o_alu_data);
    check("fwd_x0", o_alu_data, 32'h100);
    i_mem_rd_wren = 0; i_wb_rd_wren = 0; i_rs1_addr = 5'd1; i_rs2_addr = 5'd2;

    // Stall holds the register while inputs keep changing.
    i_opb_sel = 0;
    i_pc = 32'h40; i_rd_addr = 5'd9;
    alu_vec("xor", 4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'h0000_FF00);
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      i_rs1_data = 32'hDEAD_0000 + k; i_pc = 32'h80 + k; i_rd_addr = 5'd20 + 5'(k);
      i_id_valid = k[0];
      step();
      $display("vec stall%0d -> %08h pc %08h", k, o_alu_data, o_pc);
      check("stall_alu", o_alu_data, 32'h0000_FF00);
      check("stall_pc", o_pc, 32'h40);
      check("stall_v", {31'd0, o_ex_valid}, 1);
    end

    // Flush wins over stall.
    i_id_valid = 1; i_rd_wren = 1; i_flush = 1;
    step();
    $display("vec flush+stall v=%0b w=%0b", o_ex_valid, o_rd_wren);
    check("flush_v", {31'd0, o_ex_valid}, 0);
    check("flush_w", {31'd0, o_rd_wren}, 0);
    i_flush = 0; i_stall = 0;

    // Bubble: rd_wren ignored when not valid.
    i_id_valid = 0; i_rd_wren = 1;
    step();
    $display("vec bubble v=%0b w=%0b", o_ex_valid, o_rd_wren);
    check("bubble_v", {31'd0, o_ex_valid}, 0);
    check("bubble_w", {31'd0, o_rd_wren}, 0);

    // Reset while the register holds data.
    i_id_valid = 1; i_pc = 32'h55; i_rd_addr = 5'd11; i_rs2_data = 32'h77;
    alu_vec("fill", 4'd0, 32'd1, 32'd2, 1'b0, 32'd3);
    i_rst_n = 0; i_stall = 1; i_flush = 1;
    step();
    $display("vec reset2");
    check("rst2_valid", {31'd0, o_ex_valid}, 0);
    check("rst2_wren",  {31'd0, o_rd_wren}, 0);
    check("rst2_alu",   o_alu_data, 0);
    check("rst2_store", o_store_data, 0);
    check("rst2_rd",    {27'd0, o_rd_addr}, 0);
    check("rst2_pc",    o_pc, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
